rob_rsp_reorder: RTL and testbench
==================================

# rob_rsp_reorder

Response-side companion to the ROB ID allocator. It accepts responses tagged with a unique ID `{row,col}` in any order and buffers them per slot. It releases them in allocation order within each row, round-robin across rows. For each released response it issues the allocator free request and relabels the response with the restored original ID.

## Interface
Parameters:
- ID_WIDTH, 4, width of original and unique IDs
- MAX_OUTSTANDING, 16, total slots (NUM_ROWS*NUM_COLS)
- NUM_ROWS, 4, rows (original-ID bins)
- NUM_COLS, 4, slots per row
- DATA_WIDTH, 32, response payload width

Ports:
- Reset and clock: reset rst, asynchronous, active-high; clock clk.
- alloc_gnt  in  1  allocator grant (mirrors an allocation)
- alloc_uid  in  ID_WIDTH  unique ID granted that cycle
- rsp_valid  in  1  downstream response valid
- rsp_ready  out  1  response accept
- rsp_uid  in  ID_WIDTH  unique ID of response
- rsp_data  in  DATA_WIDTH  response payload
- out_valid  out  1  upstream response valid
- out_ready  in  1  upstream accept
- out_id  out  ID_WIDTH  restored original ID
- out_data  out  DATA_WIDTH  payload
- free_req  out  1  allocator free strobe
- unique_id_to_free  out  ID_WIDTH  slot being freed
- restored_id  in  ID_WIDTH  allocator combinational lookup of unique_id_to_free
- rsp_err  out  1  sticky protocol error (see Configuration)

## Operation
- Unique ID decode:
  - ROW_W=$clog2(NUM_ROWS), COL_W=$clog2(NUM_COLS).
  - row=uid[ROW_W+COL_W-1:COL_W], col=uid[COL_W-1:0].
  - Upper bits are ignored.
- Input side:
  - rsp_ready=1 whenever not in reset.
  - On rsp_valid&rsp_ready, write rsp_data to slot[row][col] and set valid[row][col].
- Per-row state:
  - head_ptr[r] (COL_W bits, wraps NUM_COLS-1→0).
  - cnt[r] (in-flight count, $clog2(NUM_COLS+1) bits).
- cnt[r] update:
  - +1 on alloc_gnt to row r.
  - −1 on free_req to row r.
  - Simultaneous alloc and free on the same row: cnt unchanged.
- Releasable row: valid[r][head_ptr[r]]=1.
- Round-robin arbiter:
  - Grants one releasable row per cycle.
  - Priority pointer moves to grant+1 after each grant.
  - Reset priority is row 0.
- Release condition: a grant exists and the output register is loadable (~out_valid | out_ready). On release, in the same cycle:
  - free_req=1 and unique_id_to_free={row,head_ptr}, both combinational.
  - Load out_data←slot and out_id←restored_id; set out_valid.
  - Clear the valid bit and increment head_ptr.
- Row drain: when cnt[r] transitions 1→0, head_ptr[r]←0. This matches the allocator's column reset when a row unbinds.
- A response arriving in the same cycle as a release of a different slot in the same row: both take effect.

## Timing
- Minimum latency is 2 cycles:
  - rsp accepted in cycle N.
  - free_req in N+1.
  - out_valid in N+2.
- There is no same-cycle write-to-release bypass.
- Output handshake:
  - out_valid, out_id and out_data hold stable until out_ready.
  - A new release may load in the cycle the current output is accepted, giving 1 response/cycle throughput.
- free_req is a single-cycle pulse per release. It is never asserted while the output is stalled.
- Reset values:
  - out_valid=0, out_id=0, out_data=0, free_req=0, rsp_err=0, rsp_ready=0.
  - All valid bits, head_ptr and cnt are 0; arbiter pointer is 0.
- Reset mid-operation discards all buffered responses.

## Configuration
- Macro: RSP_REORDER_ERR_CHECK_EN.
- When defined:
  - rsp_err sets (sticky until rst) on a response to an already-valid slot; that response is dropped.
  - rsp_err also sets on a response to a row with cnt=0.
  - rsp_err also sets on free with cnt=0.
- When undefined:
  - rsp_err is tied 0.
  - A duplicate response overwrites the slot payload.

## Structure
- Package rob_pkg holds the shared constants and typedefs:
  - ROW_W and COL_W derivations.
  - Unique-ID struct {row,col}.
  - Payload typedef.
- The same package is shared with the allocator.
- Sub-module rob_rr_arbiter (NUM_ROWS requests → one-hot grant plus index, rotating priority) is instantiated once.

## Test plan
- Single response:
  - Stimulus: alloc uid 0x0; rsp uid 0x0 data 0xA5 in cycle N; restored_id=0x7.
  - Required: free_req with uid 0x0 in N+1; out_valid with out_id=0x7 and out_data=0xA5 in N+2.
- Same-row reorder:
  - Stimulus: alloc 0x0 and 0x1; rsp 0x1 (0x11), then rsp 0x0 (0x22).
  - Required: outputs 0x22 then 0x11; nothing is released before 0x0 arrives.
- Cross-row fairness:
  - Stimulus: rows 0 and 1 each hold 2 ready responses.
  - Required: release order row0, row1, row0, row1.
- Backpressure:
  - Stimulus: out_ready=0 for 5 cycles while responses are pending.
  - Required: output stable, no free_req pulses; resumes at 1 response/cycle once out_ready=1.
- Wrap and drain:
  - Stimulus: row 2 cycles 6 allocs/responses (cols 0..3,0,1) with interleaved frees.
  - Required: head_ptr wraps 3→0; after the last free, head_ptr[2]=0, and a new alloc at col 0 releases correctly.
- Error check (with macro):
  - Stimulus: second rsp uid 0x5 while slot 0x5 is valid.
  - Required: rsp_err=1 next cycle, original payload preserved.

Source files
------------

// File: rtl/rob_rsp_reorder_pkg.sv
// rob_pkg: constants and types shared by the ROB ID allocator and the
// response reorder buffer.
//   DEF_*      default geometry (4 rows x 4 cols, 4-bit IDs, 32-bit payload)
//   ROW_W/COL_W field widths of a unique ID {row,col}
//   uid_t      unique ID as {row,col}
//   payload_t  response payload
//   clog2_min1 index width helper that never returns 0
package rob_pkg;

  localparam int DEF_ID_WIDTH        = 4;
  localparam int DEF_MAX_OUTSTANDING = 16;
  localparam int DEF_NUM_ROWS        = 4;
  localparam int DEF_NUM_COLS        = 4;
  localparam int DEF_DATA_WIDTH      = 32;

  function automatic int clog2_min1(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int ROW_W = clog2_min1(DEF_NUM_ROWS);
  localparam int COL_W = clog2_min1(DEF_NUM_COLS);

  typedef struct packed {
    logic [ROW_W-1:0] row;
    logic [COL_W-1:0] col;
  } uid_t;

  typedef logic [DEF_DATA_WIDTH-1:0] payload_t;

endpackage

// File: rtl/rob_rsp_reorder_if.sv
// rob_rsp_reorder_if: all non-clock/reset signals of the reorder buffer.
//   master: the side facing the reorder buffer (allocator + downstream +
//           upstream consumer); slave: the reorder buffer itself.
//   alloc_gnt/alloc_uid        allocation mirror
//   rsp_valid/ready/uid/data   response input
//   out_valid/ready/id/data    reordered response output
//   free_req/unique_id_to_free allocator free strobe, restored_id lookup
//   rsp_err                    sticky protocol error
interface rob_rsp_reorder_if
  import rob_pkg::*;
#(
  parameter int ID_WIDTH   = DEF_ID_WIDTH,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH
);
  logic                  alloc_gnt;
  logic [ID_WIDTH-1:0]   alloc_uid;
  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [ID_WIDTH-1:0]   rsp_uid;
  logic [DATA_WIDTH-1:0] rsp_data;
  logic                  out_valid;
  logic                  out_ready;
  logic [ID_WIDTH-1:0]   out_id;
  logic [DATA_WIDTH-1:0] out_data;
  logic                  free_req;
  logic [ID_WIDTH-1:0]   unique_id_to_free;
  logic [ID_WIDTH-1:0]   restored_id;
  logic                  rsp_err;

  modport master (
    output alloc_gnt, alloc_uid, rsp_valid, rsp_uid, rsp_data, out_ready, restored_id,
    input  rsp_ready, out_valid, out_id, out_data, free_req, unique_id_to_free, rsp_err
  );

  modport slave (
    input  alloc_gnt, alloc_uid, rsp_valid, rsp_uid, rsp_data, out_ready, restored_id,
    output rsp_ready, out_valid, out_id, out_data, free_req, unique_id_to_free, rsp_err
  );
endinterface

// File: rtl/rob_rsp_reorder_arbiter.sv
// rob_rr_arbiter: rotating-priority arbiter over N requests.
//   clk, rst   clock, async active-high reset (priority returns to 0)
//   req        request vector
//   advance    grant was consumed; priority moves to grant+1
//   gnt        one-hot grant
//   gnt_idx    index of the granted request
//   gnt_vld    some request is granted
module rob_rr_arbiter
  import rob_pkg::*;
#(
  parameter int N     = 4,
  parameter int IDX_W = clog2_min1(N)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N-1:0]     req,
  input  logic             advance,
  output logic [N-1:0]     gnt,
  output logic [IDX_W-1:0] gnt_idx,
  output logic             gnt_vld
);
  logic [IDX_W-1:0] ptr_q;
  logic [IDX_W:0]   cand;

  // Scan from the priority pointer upwards, wrapping at N.
  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    gnt_vld = 1'b0;
    cand    = '0;
    for (int i = 0; i < N; i++) begin
      cand = {1'b0, ptr_q} + (IDX_W+1)'(i);
      if (cand >= (IDX_W+1)'(N)) cand = cand - (IDX_W+1)'(N);
      if (!gnt_vld && req[cand[IDX_W-1:0]]) begin
        gnt_vld = 1'b1;
        gnt_idx = cand[IDX_W-1:0];
      end
    end
    if (gnt_vld) gnt[gnt_idx] = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_q <= '0;
    end else if (advance && gnt_vld) begin
      ptr_q <= (gnt_idx == IDX_W'(N-1)) ? '0 : gnt_idx + 1'b1;
    end
  end
endmodule

// File: rtl/rob_rsp_reorder.sv
// rob_rsp_reorder: buffers responses tagged with unique IDs {row,col} and
// releases them in allocation order per row, round-robin across rows. Each
// release pulses free_req to the allocator and relabels the response with
// the allocator's restored original ID.
//   clk, rst  clock, async active-high reset (discards buffered responses)
//   bus       rob_rsp_reorder_if.slave (alloc mirror, rsp in, out, free)
// Build option: RSP_REORDER_ERR_CHECK_EN enables the sticky rsp_err
// (duplicate response, response to idle row, free of idle row) and drops
// duplicate responses; otherwise rsp_err is 0 and duplicates overwrite.
module rob_rsp_reorder
  import rob_pkg::*;
#(
  parameter int ID_WIDTH        = DEF_ID_WIDTH,
  parameter int MAX_OUTSTANDING = DEF_MAX_OUTSTANDING,
  parameter int NUM_ROWS        = DEF_NUM_ROWS,
  parameter int NUM_COLS        = DEF_NUM_COLS,
  parameter int DATA_WIDTH      = DEF_DATA_WIDTH
) (
  input logic              clk,
  input logic              rst,
  rob_rsp_reorder_if.slave bus
);
  localparam int ROW_BITS = clog2_min1(NUM_ROWS);
  localparam int COL_BITS = clog2_min1(NUM_COLS);
  localparam int CNT_BITS = $clog2(NUM_COLS + 1);

  logic [DATA_WIDTH-1:0] slot_q  [MAX_OUTSTANDING];
  logic [NUM_COLS-1:0]   valid_q [NUM_ROWS];
  logic [COL_BITS-1:0]   head_q  [NUM_ROWS];
  logic [CNT_BITS-1:0]   cnt_q   [NUM_ROWS];

  logic [ROW_BITS-1:0]   rsp_row, alloc_row, gnt_idx;
  logic [COL_BITS-1:0]   rsp_col, rel_head;
  logic [NUM_ROWS-1:0]   req, gnt, alloc_hit, free_hit;
  logic                  gnt_vld, rel, rsp_fire, dup_rsp, wr_en;
  logic                  out_valid_q;
  logic [ID_WIDTH-1:0]   out_id_q;
  logic [DATA_WIDTH-1:0] out_data_q;

  assign rsp_row   = bus.rsp_uid[ROW_BITS+COL_BITS-1:COL_BITS];
  assign rsp_col   = bus.rsp_uid[COL_BITS-1:0];
  assign alloc_row = bus.alloc_uid[ROW_BITS+COL_BITS-1:COL_BITS];

  assign bus.rsp_ready = ~rst;
  assign rsp_fire      = bus.rsp_valid & ~rst;

  always_comb begin
    for (int r = 0; r < NUM_ROWS; r++) req[r] = valid_q[r][head_q[r]];
  end

  rob_rr_arbiter #(.N(NUM_ROWS), .IDX_W(ROW_BITS)) u_arb (
    .clk     (clk),
    .rst     (rst),
    .req     (req),
    .advance (rel),
    .gnt     (gnt),
    .gnt_idx (gnt_idx),
    .gnt_vld (gnt_vld)
  );

  // Release only when the output register can take the response, so
  // free_req never fires while the output is stalled.
  assign rel                   = gnt_vld & (~out_valid_q | bus.out_ready);
  assign rel_head              = head_q[gnt_idx];
  assign bus.free_req          = rel;
  assign bus.unique_id_to_free = ID_WIDTH'({gnt_idx, rel_head});

  always_comb begin
    alloc_hit = '0;
    if (bus.alloc_gnt) alloc_hit[alloc_row] = 1'b1;
    free_hit = gnt & {NUM_ROWS{rel}};
  end

`ifdef RSP_REORDER_ERR_CHECK_EN
  logic err_q;
  assign dup_rsp = rsp_fire & valid_q[rsp_row][rsp_col];
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_q <= 1'b0;
    end else if (dup_rsp || (rsp_fire && cnt_q[rsp_row] == '0)
                 || (rel && cnt_q[gnt_idx] == '0)) begin
      err_q <= 1'b1;
    end
  end
  assign bus.rsp_err = err_q;
`else
  assign dup_rsp     = 1'b0;
  assign bus.rsp_err = 1'b0;
`endif

  assign wr_en = rsp_fire & ~dup_rsp;

  always_ff @(posedge clk) begin
    if (wr_en) slot_q[{rsp_row, rsp_col}] <= bus.rsp_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int r = 0; r < NUM_ROWS; r++) begin
        valid_q[r] <= '0;
        head_q[r]  <= '0;
        cnt_q[r]   <= '0;
      end
    end else begin
      for (int r = 0; r < NUM_ROWS; r++) begin
        if (alloc_hit[r] && !free_hit[r]) begin
          cnt_q[r] <= cnt_q[r] + 1'b1;
        end else if (free_hit[r] && !alloc_hit[r] && cnt_q[r] != '0) begin
          cnt_q[r] <= cnt_q[r] - 1'b1;
        end
        // A row going idle restarts at column 0, as the allocator does.
        if (free_hit[r]) begin
          if (!alloc_hit[r] && cnt_q[r] == CNT_BITS'(1)) head_q[r] <= '0;
          else head_q[r] <= (head_q[r] == COL_BITS'(NUM_COLS-1)) ? '0 : head_q[r] + 1'b1;
        end
        for (int c = 0; c < NUM_COLS; c++) begin
          if (free_hit[r] && head_q[r] == COL_BITS'(c)) valid_q[r][c] <= 1'b0;
          if (wr_en && rsp_row == ROW_BITS'(r) && rsp_col == COL_BITS'(c)) valid_q[r][c] <= 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      out_id_q    <= '0;
      out_data_q  <= '0;
    end else if (rel) begin
      out_valid_q <= 1'b1;
      out_id_q    <= bus.restored_id;
      out_data_q  <= slot_q[{gnt_idx, rel_head}];
    end else if (bus.out_ready) begin
      out_valid_q <= 1'b0;
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.out_id    = out_id_q;
  assign bus.out_data  = out_data_q;
endmodule

// File: tb/tb_rob_rsp_reorder.sv
// tb_rob_rsp_reorder: scoreboard bench for rob_rsp_reorder. Expected
// outputs are queued as stimulus is issued and popped as the DUT releases.
// A small allocator model (orig_tbl) supplies restored_id.
module tb_rob_rsp_reorder;
  import rob_pkg::*;

  localparam int IW = 4;
  localparam int DW = 32;
`ifdef RSP_REORDER_ERR_CHECK_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  typedef struct {
    logic [IW-1:0] id;
    payload_t      data;
  } exp_t;

  typedef struct {
    bit       is_rsp;
    int       col;
    payload_t v;
  } op_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  rob_rsp_reorder_if #(.ID_WIDTH(IW), .DATA_WIDTH(DW)) bus ();

  rob_rsp_reorder #(
    .ID_WIDTH(IW), .MAX_OUTSTANDING(16), .NUM_ROWS(4), .NUM_COLS(4), .DATA_WIDTH(DW)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  logic [IW-1:0] orig_tbl [16];
  assign bus.restored_id = orig_tbl[bus.unique_id_to_free];

  exp_t          exp_q [$];
  logic [IW-1:0] free_q [$];
  int            n_checks = 0;
  int            n_pass   = 0;

  always @(negedge clk) begin
    if (!rst && bus.free_req) free_q.push_back(bus.unique_id_to_free);
  end

  function automatic logic [IW-1:0] mk_uid(input int row, input int col);
    uid_t u;
    u.row = row[ROW_W-1:0];
    u.col = col[COL_W-1:0];
    return IW'(u);
  endfunction

  task automatic alloc(input logic [IW-1:0] uid, input logic [IW-1:0] orig);
    orig_tbl[uid] = orig;
    bus.alloc_gnt = 1'b1;
    bus.alloc_uid = uid;
    @(posedge clk); #1;
    bus.alloc_gnt = 1'b0;
  endtask

  task automatic send_rsp(input logic [IW-1:0] uid, input payload_t d);
    bus.rsp_valid = 1'b1;
    bus.rsp_uid   = uid;
    bus.rsp_data  = d;
    @(posedge clk); #1;
    bus.rsp_valid = 1'b0;
  endtask

  // Collects one accepted output; ok=0 if none within the cycle budget.
  task automatic pull(output logic [IW-1:0] id, output payload_t d, output bit ok);
    ok = 1'b0; id = '0; d = '0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (bus.out_valid && bus.out_ready) begin
        id = bus.out_id; d = bus.out_data; ok = 1'b1;
        break;
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.alloc_gnt = 1'b0; bus.alloc_uid = '0;
    bus.rsp_valid = 1'b0; bus.rsp_uid = '0; bus.rsp_data = '0;
    bus.out_ready = 1'b1;
    for (int i = 0; i < 16; i++) orig_tbl[i] = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_checks++; if (bus.out_valid !== 1'b0) $display("FAIL reset_out_valid got=%b exp=0", bus.out_valid); else n_pass++;
    n_checks++; if (bus.out_id !== '0) $display("FAIL reset_out_id got=%h exp=0", bus.out_id); else n_pass++;
    n_checks++; if (bus.out_data !== '0) $display("FAIL reset_out_data got=%h exp=0", bus.out_data); else n_pass++;
    n_checks++; if (bus.free_req !== 1'b0) $display("FAIL reset_free_req got=%b exp=0", bus.free_req); else n_pass++;
    n_checks++; if (bus.rsp_err !== 1'b0) $display("FAIL reset_rsp_err got=%b exp=0", bus.rsp_err); else n_pass++;
    n_checks++; if (bus.rsp_ready !== 1'b0) $display("FAIL reset_rsp_ready got=%b exp=0", bus.rsp_ready); else n_pass++;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    n_checks++; if (bus.rsp_ready !== 1'b1) $display("FAIL ready_after_reset got=%b exp=1", bus.rsp_ready); else n_pass++;
    @(posedge clk); #1;
  endtask

  task automatic test_single();
    free_q.delete();
    alloc(4'h0, 4'h7);
    send_rsp(4'h0, 32'hA5);
    @(negedge clk);
    n_checks++;
    if (bus.free_req !== 1'b1 || bus.unique_id_to_free !== 4'h0)
      $display("FAIL single_free got req=%b uid=%h exp req=1 uid=0", bus.free_req, bus.unique_id_to_free);
    else n_pass++;
    n_checks++; if (bus.out_valid !== 1'b0) $display("FAIL single_early_out got=%b exp=0", bus.out_valid); else n_pass++;
    @(posedge clk); #1;
    @(negedge clk);
    n_checks++;
    if (bus.out_valid !== 1'b1 || bus.out_id !== 4'h7 || bus.out_data !== 32'hA5)
      $display("FAIL single_out got v=%b id=%h d=%h exp v=1 id=7 d=a5", bus.out_valid, bus.out_id, bus.out_data);
    else n_pass++;
    n_checks++; if (bus.free_req !== 1'b0) $display("FAIL single_free_pulse got=%b exp=0", bus.free_req); else n_pass++;
    @(posedge clk); #1;
    free_q.delete();
  endtask

  task automatic test_reorder();
    bit seen = 1'b0;
    exp_t e;
    logic [IW-1:0] id;
    payload_t d;
    bit ok;
    free_q.delete();
    alloc(4'h0, 4'h3);
    alloc(4'h1, 4'h4);
    send_rsp(4'h1, 32'h11);
    repeat (4) begin
      @(negedge clk);
      if (bus.out_valid || bus.free_req) seen = 1'b1;
    end
    @(posedge clk); #1;
    n_checks++; if (seen !== 1'b0) $display("FAIL reorder_early_release got=%b exp=0", seen); else n_pass++;
    exp_q.push_back('{4'h3, 32'h22});
    exp_q.push_back('{4'h4, 32'h11});
    send_rsp(4'h0, 32'h22);
    for (int k = 0; k < 2; k++) begin
      pull(id, d, ok);
      e = exp_q.pop_front();
      n_checks++;
      if (!ok || id !== e.id || d !== e.data)
        $display("FAIL reorder_out%0d got ok=%b id=%h d=%h exp id=%h d=%h", k, ok, id, d, e.id, e.data);
      else n_pass++;
    end
    n_checks++;
    if (free_q.size() != 2 || free_q[0] !== 4'h0 || free_q[1] !== 4'h1)
      $display("FAIL reorder_frees got n=%0d exp 0,1", free_q.size());
    else n_pass++;
    free_q.delete();
  endtask

  task automatic test_fairness();
    exp_t e;
    logic [IW-1:0] id;
    payload_t d;
    bit ok;
    free_q.delete();
    bus.out_ready = 1'b0;
    alloc(4'h0, 4'h1);
    alloc(4'h1, 4'h2);
    alloc(4'h4, 4'h5);
    alloc(4'h5, 4'h6);
    send_rsp(4'h1, 32'h101);
    send_rsp(4'h5, 32'h105);
    send_rsp(4'h0, 32'h100);
    send_rsp(4'h4, 32'h104);
    repeat (3) @(posedge clk);
    #1;
    exp_q.push_back('{4'h1, 32'h100});
    exp_q.push_back('{4'h5, 32'h104});
    exp_q.push_back('{4'h2, 32'h101});
    exp_q.push_back('{4'h6, 32'h105});
    bus.out_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      pull(id, d, ok);
      e = exp_q.pop_front();
      n_checks++;
      if (!ok || id !== e.id || d !== e.data)
        $display("FAIL fair_out%0d got ok=%b id=%h d=%h exp id=%h d=%h", k, ok, id, d, e.id, e.data);
      else n_pass++;
    end
    n_checks++;
    if (free_q.size() != 4 || free_q[0] !== 4'h0 || free_q[1] !== 4'h4 ||
        free_q[2] !== 4'h1 || free_q[3] !== 4'h5)
      $display("FAIL fair_frees got n=%0d exp 0,4,1,5", free_q.size());
    else n_pass++;
    free_q.delete();
  endtask

  task automatic test_backpressure();
    exp_t e;
    free_q.delete();
    bus.out_ready = 1'b0;
    alloc(4'hC, 4'h9);
    alloc(4'hD, 4'hA);
    alloc(4'hE, 4'hB);
    exp_q.push_back('{4'h9, 32'hC0});
    exp_q.push_back('{4'hA, 32'hD0});
    exp_q.push_back('{4'hB, 32'hE0});
    send_rsp(4'hC, 32'hC0);
    send_rsp(4'hD, 32'hD0);
    send_rsp(4'hE, 32'hE0);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      n_checks++;
      if (bus.out_valid !== 1'b1 || bus.out_id !== 4'h9 || bus.out_data !== 32'hC0 || bus.free_req !== 1'b0)
        $display("FAIL stall_cyc%0d got v=%b id=%h d=%h free=%b exp v=1 id=9 d=c0 free=0",
                 k, bus.out_valid, bus.out_id, bus.out_data, bus.free_req);
      else n_pass++;
    end
    @(posedge clk); #1;
    bus.out_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      e = exp_q.pop_front();
      n_checks++;
      if (bus.out_valid !== 1'b1 || bus.out_id !== e.id || bus.out_data !== e.data)
        $display("FAIL resume_out%0d got v=%b id=%h d=%h exp v=1 id=%h d=%h",
                 k, bus.out_valid, bus.out_id, bus.out_data, e.id, e.data);
      else n_pass++;
    end
    @(posedge clk); #1;
    n_checks++;
    if (free_q.size() != 3 || free_q[0] !== 4'hC || free_q[1] !== 4'hD || free_q[2] !== 4'hE)
      $display("FAIL bp_frees got n=%0d exp c,d,e", free_q.size());
    else n_pass++;
    free_q.delete();
  endtask

  task automatic test_wrap_drain();
    op_t ops [14];
    logic [IW-1:0] exp_free [7];
    logic [IW-1:0] uid, id;
    exp_t e;
    payload_t d;
    bit ok;
    int nf;
    ops = '{'{1'b0, 0, 32'h1}, '{1'b0, 1, 32'h2}, '{1'b0, 2, 32'h3}, '{1'b0, 3, 32'h4},
            '{1'b1, 0, 32'h80}, '{1'b0, 0, 32'h5}, '{1'b1, 1, 32'h90}, '{1'b0, 1, 32'h6},
            '{1'b1, 2, 32'hA0}, '{1'b1, 3, 32'hB0}, '{1'b1, 0, 32'h81}, '{1'b1, 1, 32'h91},
            '{1'b0, 0, 32'h7}, '{1'b1, 0, 32'h82}};
    exp_free = '{4'h8, 4'h9, 4'hA, 4'hB, 4'h8, 4'h9, 4'h8};
    free_q.delete();
    for (int i = 0; i < 14; i++) begin
      uid = mk_uid(2, ops[i].col);
      if (!ops[i].is_rsp) begin
        alloc(uid, ops[i].v[IW-1:0]);
      end else begin
        exp_q.push_back('{orig_tbl[uid], ops[i].v});
        send_rsp(uid, ops[i].v);
        pull(id, d, ok);
        e = exp_q.pop_front();
        n_checks++;
        if (!ok || id !== e.id || d !== e.data)
          $display("FAIL wrap_op%0d got ok=%b id=%h d=%h exp id=%h d=%h", i, ok, id, d, e.id, e.data);
        else n_pass++;
      end
    end
    nf = 0;
    for (int k = 0; k < 7; k++) if (k < free_q.size() && free_q[k] === exp_free[k]) nf++;
    n_checks++;
    if (free_q.size() != 7 || nf != 7)
      $display("FAIL wrap_frees got n=%0d matched=%0d exp 7", free_q.size(), nf);
    else n_pass++;
    free_q.delete();
  endtask

  task automatic test_dup_rsp();
    exp_t e;
    logic [IW-1:0] id;
    payload_t d;
    bit ok;
    alloc(4'h4, 4'h1);
    alloc(4'h5, 4'h2);
    send_rsp(4'h5, 32'hAA);
    @(negedge clk);
    n_checks++; if (bus.rsp_err !== 1'b0) $display("FAIL err_before_dup got=%b exp=0", bus.rsp_err); else n_pass++;
    @(posedge clk); #1;
    send_rsp(4'h5, 32'hBB);
    @(negedge clk);
    n_checks++; if (bus.rsp_err !== ERR_EN) $display("FAIL err_after_dup got=%b exp=%b", bus.rsp_err, ERR_EN); else n_pass++;
    @(posedge clk); #1;
    exp_q.push_back('{4'h1, 32'h44});
    exp_q.push_back('{4'h2, ERR_EN ? 32'hAA : 32'hBB});
    send_rsp(4'h4, 32'h44);
    for (int k = 0; k < 2; k++) begin
      pull(id, d, ok);
      e = exp_q.pop_front();
      n_checks++;
      if (!ok || id !== e.id || d !== e.data)
        $display("FAIL dup_out%0d got ok=%b id=%h d=%h exp id=%h d=%h", k, ok, id, d, e.id, e.data);
      else n_pass++;
    end
    free_q.delete();
  endtask

  task automatic test_reset_mid();
    bit seen = 1'b0;
    bus.out_ready = 1'b0;
    alloc(4'hC, 4'h3);
    alloc(4'hD, 4'h4);
    send_rsp(4'hC, 32'h1);
    send_rsp(4'hD, 32'h2);
    @(negedge clk);
    n_checks++; if (bus.out_valid !== 1'b1) $display("FAIL mid_pending got=%b exp=1", bus.out_valid); else n_pass++;
    rst = 1'b1;
    #1;
    n_checks++;
    if (bus.out_valid !== 1'b0 || bus.rsp_err !== 1'b0)
      $display("FAIL mid_reset_out got v=%b err=%b exp v=0 err=0", bus.out_valid, bus.rsp_err);
    else n_pass++;
    @(posedge clk); #1;
    rst = 1'b0;
    bus.out_ready = 1'b1;
    repeat (6) begin
      @(negedge clk);
      if (bus.out_valid || bus.free_req) seen = 1'b1;
    end
    @(posedge clk); #1;
    n_checks++; if (seen !== 1'b0) $display("FAIL mid_discard got=%b exp=0", seen); else n_pass++;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_single();
    test_reorder();
    test_fairness();
    test_backpressure();
    test_wrap_drain();
    test_dup_rsp();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
